// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op bit meanings, FSM encoding and
// the divide-by-zero result constant.
package mdu_pkg;

  localparam int unsigned OpMulBit    = 1;
  localparam int unsigned OpSignedBit = 0;

  // Quotient returned for a divide by zero; the remainder is the dividend.
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StMul  = ST_MUL,
    StDiv  = ST_DIV,
    StDone = ST_DONE
  } mdu_state_e;

  function automatic logic op_is_mul(input logic [1:0] op);
    return op[OpMulBit];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[OpSignedBit];
  endfunction

endpackage

// File: rtl/mdu_cnt.sv
// Shared cycle counter: counts down the multiply latency or counts up the divide watchdog.
module mdu_cnt #(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_MAX = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic load_i,
  input  logic dec_i,
  input  logic inc_i,
  output logic zero_o,
  output logic limit_hit_o
);

  localparam logic [5:0] LoadVal = 6'(MUL_LAT - 1);
  localparam logic [5:0] Limit   = 6'(DIV_MAX);
  localparam logic [5:0] LimitM1 = 6'(DIV_MAX - 1);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 6'd0;
    end else if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && cnt_q != 6'd0) begin
      cnt_d = cnt_q - 6'd1;
    end else if (inc_i && cnt_q < Limit) begin
      // Saturates at the limit so a hung divider cannot wrap the watchdog.
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o      = (cnt_q == 6'd0);
  assign limit_hit_o = inc_i && (cnt_q == LimitM1);

endmodule

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer for the EX stage: latches one request, waits on the multiplier
// or handshakes with the iterative divider, holds HI/LO and raises the EX stall.
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_MAX = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        advance_i,
  input  logic [31:0] mul_hi_i,
  input  logic [31:0] mul_lo_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_signed_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        result_valid_o,
  output logic        stall_o,
  output logic        busy_o,
  output logic        err_o
);

  mdu_state_e  state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        err_q, err_d;
  logic        latch_en;
  logic        new_req;

  logic cnt_clear, cnt_load, cnt_dec, cnt_inc;
  logic cnt_zero, cnt_limit_hit;

  mdu_cnt #(
    .MUL_LAT (MUL_LAT),
    .DIV_MAX (DIV_MAX)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (cnt_clear),
    .load_i      (cnt_load),
    .dec_i       (cnt_dec),
    .inc_i       (cnt_inc),
    .zero_o      (cnt_zero),
    .limit_hit_o (cnt_limit_hit)
  );

  assign new_req = req_valid_i && !flush_i;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    err_d     = err_q;
    latch_en  = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (new_req) begin
          latch_en = 1'b1;
          if (op_is_mul(op_i)) begin
            state_d  = StMul;
            cnt_load = 1'b1;
          end else if (src_b_i == 32'd0) begin
            // Divide by zero completes immediately without touching the divider.
            state_d = StDone;
            hi_d    = src_a_i;
            lo_d    = DIV0_LO;
          end else begin
            state_d   = StDiv;
            cnt_clear = 1'b1;
          end
        end
      end
      StMul: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (cnt_zero) begin
          state_d = StDone;
          hi_d    = mul_hi_i;
          lo_d    = mul_lo_i;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDiv: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (div_ready_i) begin
          state_d = StDone;
          hi_d    = div_result_i[63:32];
          lo_d    = div_result_i[31:0];
        end else begin
          cnt_inc = 1'b1;
          if (cnt_limit_hit) begin
            err_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (flush_i || advance_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= 2'd0;
    end else if (latch_en) begin
      a_q  <= src_a_i;
      b_q  <= src_b_i;
      op_q <= op_i;
    end
  end

  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign mul_signed_o = op_is_signed(op_q);
  assign div_a_o      = a_q;
  assign div_b_o      = b_q;
  assign div_signed_o = op_is_signed(op_q);

  assign div_start_o    = (state_q == StDiv) && !flush_i;
  assign div_annul_o    = (state_q == StDiv) && flush_i;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign result_valid_o = (state_q == StDone);
  assign busy_o         = (state_q != StIdle);
  assign err_o          = err_q;
  assign stall_o        = ((state_q == StIdle) && new_req) || (state_q == StMul) ||
                          (state_q == StDiv);

endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: a vector table for multiply and divide-by-zero, plus directed
// sequences for the divider handshake, flush, watchdog and reset.
module tb_mdu_sched;

  localparam int unsigned MUL_LAT = 1;
  localparam int unsigned DIV_MAX = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        flush_i, advance_i;
  logic [31:0] mul_hi_i, mul_lo_i;
  logic [31:0] mul_a_o, mul_b_o;
  logic        mul_signed_o;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_a_o, div_b_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic [31:0] hi_o, lo_o;
  logic        result_valid_o, stall_o, busy_o, err_o;

  int checks   = 0;
  int failures = 0;

  mdu_sched #(
    .MUL_LAT (MUL_LAT),
    .DIV_MAX (DIV_MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .op_i           (op_i),
    .src_a_i        (src_a_i),
    .src_b_i        (src_b_i),
    .flush_i        (flush_i),
    .advance_i      (advance_i),
    .mul_hi_i       (mul_hi_i),
    .mul_lo_i       (mul_lo_i),
    .mul_a_o        (mul_a_o),
    .mul_b_o        (mul_b_o),
    .mul_signed_o   (mul_signed_o),
    .div_start_o    (div_start_o),
    .div_annul_o    (div_annul_o),
    .div_signed_o   (div_signed_o),
    .div_a_o        (div_a_o),
    .div_b_o        (div_b_o),
    .div_result_i   (div_result_i),
    .div_ready_i    (div_ready_i),
    .hi_o           (hi_o),
    .lo_o           (lo_o),
    .result_valid_o (result_valid_o),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  // Combinational multiplier stub fed from the latched operands.
  logic [63:0] prod;
  always_comb begin
    if (mul_signed_o) begin
      prod = $signed({{32{mul_a_o[31]}}, mul_a_o}) * $signed({{32{mul_b_o[31]}}, mul_b_o});
    end else begin
      prod = {32'd0, mul_a_o} * {32'd0, mul_b_o};
    end
  end
  assign mul_hi_i = prod[63:32];
  assign mul_lo_i = prod[31:0];

  typedef struct {
    logic        req;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        adv;
    logic        e_stall;
    logic        e_valid;
    logic        e_start;
    logic        e_busy;
    logic        chk_res;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    op_i         = 2'b00;
    src_a_i      = 32'd0;
    src_b_i      = 32'd0;
    flush_i      = 1'b0;
    advance_i    = 1'b0;
    div_ready_i  = 1'b0;
    div_result_i = 64'd0;
  endtask

  task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    next_cycle();
    clear_inputs();
    req_valid_i = 1'b1;
    op_i        = op;
    src_a_i     = a;
    src_b_i     = b;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    chk("reset stall", 64'(stall_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset valid", 64'(result_valid_o), 64'd0);
    chk("reset err", 64'(err_o), 64'd0);
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    chk("reset mul_a", 64'(mul_a_o), 64'd0);

    // Multiply -3*7 signed, then divide 5/0; op = {mul, signed}.
    vecs[0] = '{1'b1, 2'b11, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 2'b11, 32'd4, 32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[3] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[4] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[5] = '{1'b1, 2'b01, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                32'd5, 32'hFFFF_FFFF};
    vecs[7] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                32'd5, 32'hFFFF_FFFF};
    vecs[8] = '{1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                32'd5, 32'hFFFF_FFFF};

    for (int i = 0; i < 9; i++) begin
      next_cycle();
      clear_inputs();
      req_valid_i = vecs[i].req;
      op_i        = vecs[i].op;
      src_a_i     = vecs[i].a;
      src_b_i     = vecs[i].b;
      advance_i   = vecs[i].adv;
      settle();
      chk($sformatf("v%0d stall", i), 64'(stall_o), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d valid", i), 64'(result_valid_o), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d start", i), 64'(div_start_o), 64'(vecs[i].e_start));
      chk($sformatf("v%0d busy", i), 64'(busy_o), 64'(vecs[i].e_busy));
      if (vecs[i].chk_res) begin
        chk($sformatf("v%0d hi", i), 64'(hi_o), 64'(vecs[i].e_hi));
        chk($sformatf("v%0d lo", i), 64'(lo_o), 64'(vecs[i].e_lo));
      end
    end

    // divu 100/7 with the divider ready at cycle 36, then DONE held three cycles.
    start_req(2'b00, 32'd100, 32'd7);
    settle();
    chk("divu c0 stall", 64'(stall_o), 64'd1);
    chk("divu c0 start", 64'(div_start_o), 64'd0);
    for (int c = 1; c <= 36; c++) begin
      next_cycle();
      clear_inputs();
      div_ready_i  = (c == 36);
      div_result_i = (c == 36) ? {32'd2, 32'd14} : 64'd0;
      settle();
      chk($sformatf("divu c%0d start", c), 64'(div_start_o), 64'd1);
      chk($sformatf("divu c%0d stall", c), 64'(stall_o), 64'd1);
      if (c == 1) begin
        chk("divu div_a", 64'(div_a_o), 64'd100);
        chk("divu div_b", 64'(div_b_o), 64'd7);
        chk("divu signed", 64'(div_signed_o), 64'd0);
      end
    end
    for (int c = 37; c <= 39; c++) begin
      next_cycle();
      clear_inputs();
      req_valid_i = 1'b1;
      op_i        = 2'b10;
      src_a_i     = 32'd3;
      src_b_i     = 32'd3;
      settle();
      chk($sformatf("divu c%0d valid", c), 64'(result_valid_o), 64'd1);
      chk($sformatf("divu c%0d start", c), 64'(div_start_o), 64'd0);
      chk($sformatf("divu c%0d stall", c), 64'(stall_o), 64'd0);
      chk($sformatf("divu c%0d hi", c), 64'(hi_o), 64'd2);
      chk($sformatf("divu c%0d lo", c), 64'(lo_o), 64'd14);
      chk($sformatf("divu c%0d div_a", c), 64'(div_a_o), 64'd100);
    end
    next_cycle();
    clear_inputs();
    advance_i = 1'b1;
    settle();
    chk("divu c40 valid", 64'(result_valid_o), 64'd1);
    next_cycle();
    clear_inputs();
    settle();
    chk("divu c41 busy", 64'(busy_o), 64'd0);
    chk("divu c41 valid", 64'(result_valid_o), 64'd0);

    // Flush at cycle 10 of a divide.
    start_req(2'b00, 32'd50, 32'd3);
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      clear_inputs();
      flush_i = (c == 10);
      settle();
      if (c == 9) chk("flush c9 annul", 64'(div_annul_o), 64'd0);
      if (c == 10) begin
        chk("flush c10 annul", 64'(div_annul_o), 64'd1);
        chk("flush c10 start", 64'(div_start_o), 64'd0);
      end
      if (c == 11) begin
        chk("flush c11 busy", 64'(busy_o), 64'd0);
        chk("flush c11 annul", 64'(div_annul_o), 64'd0);
        chk("flush c11 valid", 64'(result_valid_o), 64'd0);
        chk("flush c11 stall", 64'(stall_o), 64'd0);
      end
    end

    // Flush coincident with ready: result dropped, HI/LO keep the 100/7 result.
    start_req(2'b01, 32'hFFFF_FFEC, 32'd3);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      clear_inputs();
      flush_i      = (c == 3);
      div_ready_i  = (c == 3);
      div_result_i = (c == 3) ? 64'hAAAA_AAAA_5555_5555 : 64'd0;
      settle();
      if (c == 3) begin
        chk("flrdy annul", 64'(div_annul_o), 64'd1);
        chk("flrdy start", 64'(div_start_o), 64'd0);
      end
      if (c >= 4) begin
        chk($sformatf("flrdy c%0d valid", c), 64'(result_valid_o), 64'd0);
        chk($sformatf("flrdy c%0d busy", c), 64'(busy_o), 64'd0);
        chk($sformatf("flrdy c%0d hi", c), 64'(hi_o), 64'd2);
        chk($sformatf("flrdy c%0d lo", c), 64'(lo_o), 64'd14);
      end
    end

    // Divider never readies: watchdog fires at DIV_MAX+1, stall holds until flush.
    start_req(2'b00, 32'd1, 32'd1);
    for (int c = 1; c <= int'(DIV_MAX) + 5; c++) begin
      next_cycle();
      clear_inputs();
      settle();
      if (c >= int'(DIV_MAX) - 1) begin
        chk($sformatf("wdog c%0d err", c), 64'(err_o), (c > int'(DIV_MAX)) ? 64'd1 : 64'd0);
        chk($sformatf("wdog c%0d stall", c), 64'(stall_o), 64'd1);
      end
    end
    next_cycle();
    clear_inputs();
    flush_i = 1'b1;
    settle();
    chk("wdog flush annul", 64'(div_annul_o), 64'd1);
    next_cycle();
    clear_inputs();
    settle();
    chk("wdog idle stall", 64'(stall_o), 64'd0);
    chk("wdog idle busy", 64'(busy_o), 64'd0);
    chk("wdog err sticky", 64'(err_o), 64'd1);

    // Synchronous reset at cycle 5 of a signed divide.
    start_req(2'b01, 32'd9, 32'd2);
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      clear_inputs();
      rst = (c == 5);
      settle();
      if (c == 5) chk("rst c5 annul", 64'(div_annul_o), 64'd0);
    end
    chk("rst c6 stall", 64'(stall_o), 64'd0);
    chk("rst c6 busy", 64'(busy_o), 64'd0);
    chk("rst c6 valid", 64'(result_valid_o), 64'd0);
    chk("rst c6 start", 64'(div_start_o), 64'd0);
    chk("rst c6 annul", 64'(div_annul_o), 64'd0);
    chk("rst c6 err", 64'(err_o), 64'd0);
    chk("rst c6 hi", 64'(hi_o), 64'd0);
    chk("rst c6 lo", 64'(lo_o), 64'd0);
    chk("rst c6 div_a", 64'(div_a_o), 64'd0);
    chk("rst c6 div_b", 64'(div_b_o), 64'd0);
    chk("rst c6 mul_b", 64'(mul_b_o), 64'd0);
    chk("rst c6 div_signed", 64'(div_signed_o), 64'd0);
    chk("rst c6 mul_signed", 64'(mul_signed_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
- Sequencing controller for the multiply/divide resource used by the EX stage.
- Accepts one mult/div request at a time from EX and latches the operands.
- Waits a fixed multiply latency, or drives the iterative divider through its start/annul/ready handshake.
- Holds the 64-bit HI/LO result until the pipeline advances, and generates the EX stall. It replaces the ad-hoc combinational start/stall logic in the datapath.

Parameters:
- MUL_LAT, 1, cycles the latched operands must be held before the multiplier output is sampled (legal range 1..15).
- DIV_MAX, 40, watchdog limit in cycles for a divide; exceeding it raises err_o.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  EX holds an md instruction that writes HI/LO (mdToHilo)
- op_i  in  2  bit1: 1=mul, 0=div; bit0: 1=signed
- src_a_i  in  32  rs operand, already forwarded
- src_b_i  in  32  rt operand, already forwarded
- flush_i  in  1  EX flush; kills the in-flight op
- advance_i  in  1  EX register accepts new contents this cycle (no other stall)
- mul_hi_i  in  32  multiplier high product, computed from mul_a_o/mul_b_o
- mul_lo_i  in  32  multiplier low product
- mul_a_o  out  32  latched operand a to multiplier
- mul_b_o  out  32  latched operand b to multiplier
- mul_signed_o  out  1  latched sign mode to multiplier
- div_start_o  out  1  divider start, level
- div_annul_o  out  1  divider annul, 1-cycle pulse
- div_signed_o  out  1  latched sign mode to divider
- div_a_o  out  32  latched dividend
- div_b_o  out  32  latched divisor
- div_result_i  in  64  {remainder, quotient}
- div_ready_i  in  1  divider done, 1-cycle pulse
- hi_o  out  32  result HI (MUL: high product; DIV: remainder)
- lo_o  out  32  result LO (MUL: low product; DIV: quotient)
- result_valid_o  out  1  hi_o/lo_o valid for the EX instruction
- stall_o  out  1  stall request to hazard unit (stallE and upstream)
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky divide watchdog error

Behaviour:
- Reset:
  - state=IDLE; all registered outputs 0; err_o=0; counter=0.
  - Reset mid-operation drops the op silently; no annul pulse is emitted.
- States: IDLE, MUL, DIV, DONE. Encoding is in the package.
- IDLE:
  - If req_valid_i & ~flush_i: latch src_a_i, src_b_i, op_i.
  - mul → MUL with cnt=MUL_LAT-1.
  - div with src_b_i==0 → DONE with hi=src_a_i, lo=32'hFFFF_FFFF. Divider is not started.
  - div otherwise → DIV with cnt=0.
- MUL:
  - cnt decrements each cycle.
  - When cnt==0, register mul_hi_i/mul_lo_i into hi/lo → DONE.
- DIV:
  - div_start_o=1 every cycle in DIV until div_ready_i.
  - On div_ready_i: hi=div_result_i[63:32], lo=div_result_i[31:0] → DONE.
  - cnt increments each cycle. Reaching DIV_MAX sets err_o and stays in DIV.
- DONE:
  - result_valid_o=1.
  - If advance_i → IDLE. The request is not restarted while waiting; req_valid_i is ignored in DONE.
- stall_o is combinational: (IDLE & req_valid_i & ~flush_i) | MUL | DIV. It is 0 in DONE.
- Timing, with the request first seen at cycle 0:
  - MUL: stall_o high cycles 0..MUL_LAT; result_valid_o from cycle MUL_LAT+1.
  - DIV: ready at cycle k gives result_valid_o from k+1.
  - Div-by-zero: result_valid_o at cycle 1.
- Back-to-back requests: after DONE→IDLE, a new request is sampled the following cycle. There is no same-cycle restart.
- flush_i has highest priority in every state → IDLE next cycle.
  - In DIV, flush also gives div_annul_o=1 for exactly that cycle and div_start_o=0 that cycle.
  - If flush_i and div_ready_i coincide: flush wins, the result is discarded, and annul is still pulsed.
- Operand outputs (mul_*, div_*) are driven only from latched registers and stay stable for the whole op.
- hi_o/lo_o hold their last value outside DONE.

Decomposition:
- Shared package mdu_pkg: op_i bit meanings; state encoding localparams; DIV0_LO constant 32'hFFFF_FFFF.
- One sub-module, mdu_cnt: 4-bit down-counter for the MUL wait and 6-bit up-counter with limit compare for the DIV watchdog. A single shared register is acceptable.

Test Plan:
- Reset, then req mul signed, a=-3, b=7, MUL_LAT=1, stub multiplier → stall_o cycles 0-1; result_valid_o cycle 2; hi=FFFF_FFFF, lo=FFFF_FFEB.
- Req divu a=100, b=7; stub divider asserts ready at cycle 36 → div_start_o cycles 1-36; lo=14, hi=2 at cycle 37; DONE held while advance_i=0 for 3 cycles, no restart.
- Req div a=5, b=0 → no div_start_o; cycle 1 hi=5, lo=FFFF_FFFF; stall_o only in cycle 0.
- Req divu, flush_i at cycle 10 → div_annul_o pulse at cycle 10; IDLE at cycle 11; no result_valid_o.
- flush_i coincident with div_ready_i → result discarded, annul pulsed. Separately, rst at cycle 5 of a div → all outputs 0 at cycle 6.
- Divider stub never readies → err_o set at cycle DIV_MAX+1; stall_o stays 1 until flush.
